// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter that shares one T-bit output channel
// among N = 2**S requesters. A winner holds the channel for up to MAX_BURST
// beats under a valid/ready handshake. After that, priority rotates so the
// released requester ranks lowest at the next arbitration. The data path is
// an internal recurse_mux driven by the registered select ctrl.
//
// Optional feature: define MUX_RR_ARB_LOCK_EN to add the lock input. While
// lock=1 in BUSY, the burst limit is suppressed; only dropping the request
// ends the grant.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   lock       in   (MUX_RR_ARB_LOCK_EN only) suppress burst-limit release
//   req        in   [N-1:0]   per-requester request
//   in         in   [N*T-1:0] concatenated requester data, slice i = in[i*T +: T]
//   out_ready  in   downstream accepts a beat
//   out_valid  out  out_data holds a valid beat
//   out_data   out  [T-1:0]   slice ctrl of in
//   grant      out  [N-1:0]   one-hot grant, zero when idle
//   ctrl       out  [S-1:0]   registered mux select (granted index)
//   ack        out  [N-1:0]   per-requester beat accept

// recurse_mux: 2**S : 1 mux of T-bit slices, built as a tree of 2:1 stages.
// Ports: in (2**S slices), sel (S bits), out (selected slice).
module recurse_mux #(
   parameter int unsigned S = 2,
   parameter int unsigned T = 8
) (
   input  logic [(1 << S)*T-1:0] in,
   input  logic [S-1:0]          sel,
   output logic [T-1:0]          out
);

   generate
      if (S == 1) begin : g_leaf
         assign out = sel[0] ? in[2*T-1:T] : in[T-1:0];
      end else begin : g_node
         localparam int unsigned H = (1 << (S - 1)) * T;
         logic [T-1:0] lo;
         logic [T-1:0] hi;

         recurse_mux #(.S(S - 1), .T(T)) u_lo (
            .in  (in[H-1:0]),
            .sel (sel[S-2:0]),
            .out (lo)
         );

         recurse_mux #(.S(S - 1), .T(T)) u_hi (
            .in  (in[2*H-1:H]),
            .sel (sel[S-2:0]),
            .out (hi)
         );

         assign out = sel[S-1] ? hi : lo;
      end
   endgenerate

endmodule

module mux_rr_arbiter #(
   parameter int unsigned S         = 2,
   parameter int unsigned T         = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef MUX_RR_ARB_LOCK_EN
   input  logic                  lock,
`endif
   input  logic [(1 << S)-1:0]   req,
   input  logic [(1 << S)*T-1:0] in,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [T-1:0]          out_data,
   output logic [(1 << S)-1:0]   grant,
   output logic [S-1:0]          ctrl,
   output logic [(1 << S)-1:0]   ack
);

   localparam int unsigned N  = 1 << S;
   localparam int unsigned CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] LastBeat = CW'(MAX_BURST - 1);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [S-1:0]    ctrl_q, ctrl_d;
   logic [S-1:0]    last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [S-1:0]    winner;
   logic            found;
   logic            xfer;
   logic            lock_hold;

`ifdef MUX_RR_ARB_LOCK_EN
   assign lock_hold = lock;
`else
   assign lock_hold = 1'b0;
`endif

   // Rotating priority search starting just above the last winner. Offsets
   // wrap naturally in S bits since N is a power of two; offset N lands on
   // last itself, which therefore has the lowest priority.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = 1; i <= N; i++) begin
         if (!found && req[last_q + S'(i)]) begin
            winner = last_q + S'(i);
            found  = 1'b1;
         end
      end
   end

   assign out_valid = (state_q == StBusy) && req[ctrl_q];
   assign xfer      = out_valid && out_ready;
   assign grant     = grant_q;
   assign ctrl      = ctrl_q;
   assign ack       = grant_q & {N{xfer}};

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ctrl_d  = ctrl_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               ctrl_d  = winner;
               grant_d = {{(N-1){1'b0}}, 1'b1} << winner;
               last_d  = winner;
               cnt_d   = '0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (!req[ctrl_q]) begin
               state_d = StIdle;
               grant_d = '0;
            end else if (xfer) begin
               if (cnt_q == LastBeat && !lock_hold) begin
                  state_d = StIdle;
                  grant_d = '0;
               end else if (cnt_q != LastBeat) begin
                  cnt_d = cnt_q + 1'b1;
               end
               // Locked at the last beat: the count saturates.
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         grant_q <= '0;
         ctrl_q  <= '0;
         last_q  <= S'(N - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ctrl_q  <= ctrl_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   recurse_mux #(.S(S), .T(T)) u_mux (
      .in  (in),
      .sel (ctrl_q),
      .out (out_data)
   );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter at S=2, T=8, MAX_BURST=4. Inputs change
// 1 time unit after a rising edge; outputs are sampled 1 unit later.
module tb_mux_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] in_bus;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [3:0]  grant;
   logic [1:0]  ctrl;
   logic [3:0]  ack;
`ifdef MUX_RR_ARB_LOCK_EN
   logic        lock;
`endif

   int total = 0;
   int bad   = 0;

   logic [7:0] dat [4];

   always #5 clk = ~clk;

   mux_rr_arbiter #(.S(2), .T(8), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef MUX_RR_ARB_LOCK_EN
      .lock      (lock),
`endif
      .req       (req),
      .in        (in_bus),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .grant     (grant),
      .ctrl      (ctrl),
      .ack       (ack)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] eg, input logic ev,
                          input logic [7:0] ed, input logic [3:0] ea);
      #1;
      total++;
      assert (grant === eg) else begin
         bad++;
         $error("FAIL %s grant obs=%b exp=%b", tag, grant, eg);
      end
      total++;
      assert (out_valid === ev) else begin
         bad++;
         $error("FAIL %s out_valid obs=%b exp=%b", tag, out_valid, ev);
      end
      total++;
      assert (out_data === ed) else begin
         bad++;
         $error("FAIL %s out_data obs=%h exp=%h", tag, out_data, ed);
      end
      total++;
      assert (ack === ea) else begin
         bad++;
         $error("FAIL %s ack obs=%b exp=%b", tag, ack, ea);
      end
   endtask

   task automatic chk_ctrl(input string tag, input logic [1:0] ec);
      total++;
      assert (ctrl === ec) else begin
         bad++;
         $error("FAIL %s ctrl obs=%0d exp=%0d", tag, ctrl, ec);
      end
   endtask

   initial begin
      logic [3:0] oh;
      int         seq [5];
      dat = '{8'h11, 8'h22, 8'h33, 8'h44};
      seq = '{0, 1, 2, 3, 0};
      in_bus    = {dat[3], dat[2], dat[1], dat[0]};
      req       = 4'b0000;
      out_ready = 1'b0;
`ifdef MUX_RR_ARB_LOCK_EN
      lock      = 1'b0;
`endif
      rst_n     = 1'b0;

      // 1: reset, then idle with no requests
      chk_out("reset", 4'b0000, 1'b0, 8'h11, 4'b0000);
      chk_ctrl("reset", 2'd0);
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk_out("idle", 4'b0000, 1'b0, 8'h11, 4'b0000);
         chk_ctrl("idle", 2'd0);
      end

      // 2: single requester 2, four-beat burst, one idle cycle, regrant
      req       = 4'b0100;
      out_ready = 1'b1;
      cyc();
      chk_ctrl("t2_grant", 2'd2);
      for (int b = 0; b < 4; b++) begin
         chk_out("t2_beat", 4'b0100, 1'b1, 8'h33, 4'b0100);
         cyc();
      end
      chk_out("t2_gap", 4'b0000, 1'b0, 8'h33, 4'b0000);
      cyc();
      chk_out("t2_regrant", 4'b0100, 1'b1, 8'h33, 4'b0100);
      req = 4'b0000;
      chk_out("t2_drop", 4'b0100, 1'b0, 8'h33, 4'b0000);
      cyc();
      chk_out("t2_idle", 4'b0000, 1'b0, 8'h33, 4'b0000);

      // 3: all requesting after reset -> order 0,1,2,3,0
      rst_n = 1'b0;
      chk_out("t3_rst", 4'b0000, 1'b0, 8'h11, 4'b0000);
      rst_n = 1'b1;
      req   = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         oh = 4'b0001 << seq[k];
         cyc();
         chk_ctrl("t3_ctrl", 2'(seq[k]));
         for (int b = 0; b < 4; b++) begin
            chk_out("t3_beat", oh, 1'b1, dat[seq[k]], oh);
            cyc();
         end
         chk_out("t3_gap", 4'b0000, 1'b0, dat[seq[k]], 4'b0000);
      end

      // 4: requester 1 stalled mid-burst for 3 cycles
      req = 4'b0010;
      cyc();
      chk_out("t4_beat0", 4'b0010, 1'b1, 8'h22, 4'b0010);
      cyc();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_out("t4_stall", 4'b0010, 1'b1, 8'h22, 4'b0000);
         if (i < 3) cyc();
      end
      out_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         chk_out("t4_rest", 4'b0010, 1'b1, 8'h22, 4'b0010);
         cyc();
      end
      chk_out("t4_done", 4'b0000, 1'b0, 8'h22, 4'b0000);

      // 5: requester 3 drops after 2 beats, pending 0 wins next
      req = 4'b1001;
      cyc();
      chk_out("t5_grant", 4'b1000, 1'b1, 8'h44, 4'b1000);
      cyc();
      cyc();
      req = 4'b0001;
      chk_out("t5_drop", 4'b1000, 1'b0, 8'h44, 4'b0000);
      cyc();
      chk_out("t5_idle", 4'b0000, 1'b0, 8'h44, 4'b0000);
      cyc();
      chk_out("t5_next", 4'b0001, 1'b1, 8'h11, 4'b0001);

      // 6: reset mid-burst, arbitration restarts at 0
      cyc();
      req   = 4'b1111;
      rst_n = 1'b0;
      chk_out("t6_rst", 4'b0000, 1'b0, 8'h11, 4'b0000);
      chk_ctrl("t6_rst", 2'd0);
      cyc();
      chk_out("t6_hold", 4'b0000, 1'b0, 8'h11, 4'b0000);
      rst_n = 1'b1;
      cyc();
      chk_out("t6_restart", 4'b0001, 1'b1, 8'h11, 4'b0001);
      req = 4'b0000;
      cyc();

`ifdef MUX_RR_ARB_LOCK_EN
      // 7: locked burst of 10 beats from requester 2 (last=0 -> 1,2 searched)
      lock = 1'b1;
      req  = 4'b0100;
      cyc();
      for (int b = 0; b < 10; b++) begin
         chk_out("t7_lock", 4'b0100, 1'b1, 8'h33, 4'b0100);
         cyc();
      end
      lock = 1'b0;
      chk_out("t7_unlock", 4'b0100, 1'b1, 8'h33, 4'b0100);
      cyc();
      chk_out("t7_release", 4'b0000, 1'b0, 8'h33, 4'b0000);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one T-bit output channel among 2**S requesters.
- Drives the select input of an internal recurse_mux instance (S select bits, T data width); the mux itself is unchanged.
- Holds a grant for a burst of beats under a valid/ready handshake, then rotates priority.
- Sits between a bank of producers and a single downstream consumer.

Parameters:
- S, 2, number of select bits; number of requesters N = 2**S.
- T, 8, data width per requester.
- MAX_BURST, 4, maximum beats per grant before forced re-arbitration; legal range 1..256.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- req  input  N  per-requester request; bit i means requester i has a beat ready on its data slice.
- in  input  N*T  concatenated requester data; slice i is in[i*T +: T].
- out_ready  input  1  downstream accepts a beat this cycle.
- out_valid  output  1  out_data holds a valid beat.
- out_data  output  T  muxed data, equal to slice ctrl of in.
- grant  output  N  one-hot grant; all zero when idle.
- ctrl  output  S  registered mux select; equals the index of the granted requester.
- ack  output  N  per-requester beat accept, defined as grant & {N{out_valid & out_ready}}.

Behaviour:
- Reset values (async, while rst_n=0):
  - state=IDLE, grant=0, ctrl=0, beat_cnt=0, last=N-1.
  - out_valid=0, ack=0. out_data follows in[0 +: T].
- State IDLE:
  - grant=0 and out_valid=0.
  - If req!=0, select the first set bit searching (last+1) mod N upward with wrap.
  - On that clock edge: ctrl<=winner, grant<=onehot(winner), last<=winner, beat_cnt<=0, state<=BUSY.
  - If req==0, stay in IDLE.
- Arbitration latency: req rises at edge k, grant is visible after edge k+1. There is no bypass.
- State BUSY, with g=ctrl:
  - out_valid = req[g], combinational.
  - out_data = in[g*T +: T] through recurse_mux, combinational.
  - A transfer occurs when out_valid & out_ready.
- BUSY transitions, in priority order:
  - req[g]=0: state<=IDLE, grant<=0, no transfer that cycle.
  - Transfer and beat_cnt==MAX_BURST-1: state<=IDLE, grant<=0. This is the last beat of the burst.
  - Transfer otherwise: beat_cnt<=beat_cnt+1.
  - No transfer (out_ready=0): hold all state. The requester must keep its data stable while req[g]=1.
- Fairness:
  - After a release, the released requester has the lowest priority at the next arbitration.
  - A single continuous requester alternates MAX_BURST beats with one IDLE cycle.
- Simultaneous events:
  - A new req that rises while BUSY is ignored until IDLE.
  - req[g] falling in the same cycle as out_ready=1 gives no transfer.
- Reset mid-burst: the channel is dropped immediately. out_valid and grant go to 0 asynchronously, and no partial-burst state is kept.
- Width rules:
  - beat_cnt width is clog2(MAX_BURST), minimum 1.
  - When MAX_BURST=1, every transfer returns to IDLE.
  - ctrl never takes a value outside 0..N-1.

Optional Feature:
- MUX_RR_ARB_LOCK_EN adds input port lock (1 bit).
- With the macro defined: while state=BUSY and lock=1, the MAX_BURST termination is suppressed. beat_cnt saturates at MAX_BURST-1, and the grant is released only by req[g]=0.
- lock is sampled only in BUSY. Its value has no effect in IDLE.
- Without the macro: the port does not exist and the burst limit always applies.

Test Plan (S=2, T=8, MAX_BURST=4):
1. Reset, then req=0000 for 5 cycles -> grant=0000, out_valid=0, ctrl=0 throughout.
2. in slices = 8'h11, 8'h22, 8'h33, 8'h44; req=0100; out_ready=1 -> grant=0100 one cycle later, ctrl=2. Four beats of out_data=8'h33 with ack=0100, then grant=0000 for one cycle, then regrant to 2.
3. req=1111, out_ready=1 held -> grant sequence 0001, 1000? No: from last=3 after reset, order is 0, 1, 2, 3, 0. Each grant lasts 4 beats, separated by one IDLE cycle. out_data cycles 11, 22, 33, 44.
4. Granted to 1, out_ready=0 for 3 cycles mid-burst -> out_valid=1, beat_cnt frozen, out_data=8'h22 stable. The burst completes the remaining beats after out_ready returns to 1.
5. Granted to 3 after 2 beats, req[3] drops -> out_valid=0 that cycle, no ack, IDLE next cycle. A pending req[0] is granted next, since 0 follows 3.
6. Assert rst_n=0 mid-burst -> grant=0 and out_valid=0 immediately. After release, arbitration restarts from requester 0.
7. With MUX_RR_ARB_LOCK_EN defined: lock=1 and req[2] held for 10 beats -> 10 consecutive transfers from requester 2, with no IDLE cycle.
